imem_loader: RTL

Program loader that writes into the core's instruction memory through its write port. The instruction memory is a 256 x 32-bit word array, word-addressed by PC[9:2], and is preset to NOP (ADDI x0,x0,0). This block accepts a little-endian byte stream over a valid/ready handshake and assembles it into 32-bit instruction words. It first re-fills the whole array with NOPs, then writes words from index 0 upward, and holds the CPU in reset while loading. It sits between the host/debug byte source and the Inst_MEM write port.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants and FSM state codes for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imem_pkg;

  localparam int          IMEM_DEPTH  = 256;
  localparam int          IMEM_ADDR_W = 8;
  localparam logic [31:0] NOP_INST    = 32'h00000013;  // ADDI x0,x0,0

  // Loader FSM encoding, kept as plain constants so older tools can read it
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Latency: word/word_valid are combinational with the 4th accepted byte.
// Backpressure: none of its own; it only counts bytes the parent accepts.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] lo_bytes;

  // The 4th byte is never stored: it goes straight into the top lane.
  assign word_valid = accept && (byte_cnt == 2'd3);
  assign word       = {in_data, lo_bytes};

  // Byte counter and lower-lane capture; clear re-aligns for a new load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      lo_bytes <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    lo_bytes[7:0]   <= in_data;
        2'd1:    lo_bytes[15:8]  <= in_data;
        2'd2:    lo_bytes[23:16] <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Clears the instruction memory to NOPs, then writes a streamed program from word 0 up.
// Latency: clear takes DEPTH cycles; each word is written the cycle after its 4th byte.
// Backpressure: in_ready is low outside LOAD and in the final-write cycle of LOAD.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter int          ADDR_W   = IMEM_ADDR_W,
  parameter logic [31:0] NOP_WORD = NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                DEPTH_M1  = DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = DEPTH_M1[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH_V   = DEPTH[ADDR_W:0];

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] word_idx;

  logic        accept;
  logic        word_valid;
  logic [31:0] word;
  logic        idle_like;
  logic        start_ok;
  logic        start_take;
  logic        last_word;
  logic        final_write;

  assign accept      = in_valid && in_ready;
  assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
  assign start_ok    = (load_len != '0) && (load_len <= DEPTH_V);
  assign start_take  = idle_like && start && start_ok;
  // word_idx never reaches len, so the last word is the one at len-1
  assign last_word   = word_valid && ({1'b0, word_idx} == (len - 1'b1));
  assign final_write = mem_we && ({1'b0, mem_waddr} == (len - 1'b1));

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_take),
    .accept     (accept),
    .in_data    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader FSM: all outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      word_idx  <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (start_ok) begin
              state     <= ST_CLEAR;
              len       <= load_len;
              word_idx  <= '0;
              mem_we    <= 1'b1;
              mem_waddr <= '0;
              mem_wdata <= NOP_WORD;
              busy      <= 1'b1;
              cpu_hold  <= 1'b1;
              done      <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (mem_waddr == LAST_ADDR) begin
            state    <= ST_LOAD;
            mem_we   <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            mem_waddr <= mem_waddr + 1'b1;
          end
        end
        ST_LOAD: begin
          if (final_write) begin
            state    <= ST_DONE;
            mem_we   <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            mem_we <= word_valid;
            if (word_valid) begin
              mem_waddr <= word_idx;
              mem_wdata <= word;
              if (last_word) begin
                // stop taking bytes while the last word is written
                in_ready <= 1'b0;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
